// File: rtl/triangle_raster.sv
// Bounding-box triangle rasterizer: walks the vertex bounding box row-major,
// one candidate point per cycle, and emits each point the external tester flags as inside.
module triangle_raster #(
    parameter int W  = 11,
    parameter int CW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  p1x,
    input  logic [W-1:0]  p1y,
    input  logic [W-1:0]  p2x,
    input  logic [W-1:0]  p2y,
    input  logic [W-1:0]  p3x,
    input  logic [W-1:0]  p3y,
    output logic [W-1:0]  pt_x,
    output logic [W-1:0]  pt_y,
    input  logic          inside_in,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [W-1:0]  pix_x,
    output logic [W-1:0]  pix_y,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BBOX = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
    logic [W-1:0]  xmin_q, xmax_q, ymin_q, ymax_q;
    logic [W-1:0]  xmin_d, xmax_d, ymin_d, ymax_d;
    logic [W-1:0]  cx_q, cy_q, cx_d, cy_d;
    logic [CW-1:0] count_q, count_d;

    logic accept;
    logic advance;
    logic at_xmax;
    logic at_end;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    assign accept  = in_valid && (state_q == IDLE);
    assign advance = (state_q == SCAN) && (!pix_valid || pix_ready);
    assign at_xmax = (cx_q == xmax_q);
    assign at_end  = at_xmax && (cy_q == ymax_q);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through this block can leave state_d unassigned (latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BBOX;
            BBOX:    state_d = SCAN;
            SCAN:    if (advance && at_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        pix_valid = (state_q == SCAN) && inside_in;
        pt_x      = cx_q;
        pt_y      = cy_q;
        pix_x     = cx_q;
        pix_y     = cy_q;
    end

    // ----------------------------------------------------------- datapath
    // The cursor doubles as the candidate point, so it is left untouched on the
    // final advance and outside SCAN to keep pt_x/pt_y holding their last value.
    always_comb begin
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        count_d = count_q;

        if (state_q == BBOX) begin
            xmin_d = min3(v1x_q, v2x_q, v3x_q);
            xmax_d = max3(v1x_q, v2x_q, v3x_q);
            ymin_d = min3(v1y_q, v2y_q, v3y_q);
            ymax_d = max3(v1y_q, v2y_q, v3y_q);
            cx_d   = xmin_d;
            cy_d   = ymin_d;
        end else if (advance && !at_end) begin
            if (!at_xmax) begin
                cx_d = cx_q + W'(1);
            end else begin
                cx_d = xmin_q;
                cy_d = cy_q + W'(1);
            end
        end

        if (accept) begin
            count_d = '0;
        end else if (pix_valid && pix_ready && (count_q != {CW{1'b1}})) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            count_q <= '0;
        end else begin
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            count_q <= count_d;
        end
    end

    // NOTE: vertex latches carry no reset; they are always written on accept before BBOX reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            v1x_q <= p1x;
            v1y_q <= p1y;
            v2x_q <= p2x;
            v2y_q <= p2y;
            v3x_q <= p3x;
            v3y_q <= p3y;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_triangle_raster.sv
// Self-checking bench for triangle_raster: directed scenarios plus random triangles
// scored against an edge-function coverage model and a row-major bounding-box walk.
module tb_triangle_raster;

    localparam int W  = 11;
    localparam int CW = 22;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  p1x, p1y, p2x, p2y, p3x, p3y;
    logic [W-1:0]  pt_x, pt_y;
    logic          inside_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [W-1:0]  pix_x, pix_y;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    int n_cmp;
    int n_fail;
    int stall_cnt;
    logic [31:0] got_q[$];

    bit edge_mode;
    int ax, ay, bx, by, qx, qy;

    triangle_raster #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p1x       (p1x),
        .p1y       (p1y),
        .p2x       (p2x),
        .p2y       (p2y),
        .p3x       (p3x),
        .p3y       (p3y),
        .pt_x      (pt_x),
        .pt_y      (pt_y),
        .inside_in (inside_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed triangle (edges included) via signed edge functions; collinear sets cover their line.
    function automatic bit tri_inside(input int px, input int py, input int x1, input int y1,
                                      input int x2, input int y2, input int x3, input int y3);
        int e0, e1, e2;
        e0 = (x2 - x1) * (py - y1) - (y2 - y1) * (px - x1);
        e1 = (x3 - x2) * (py - y2) - (y3 - y2) * (px - x2);
        e2 = (x1 - x3) * (py - y3) - (y1 - y3) * (px - x3);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    assign inside_in = edge_mode ? tri_inside(int'(pt_x), int'(pt_y), ax, ay, bx, by, qx, qy)
                                 : 1'b1;

    always @(negedge clk) begin
        if (!rst && pix_valid && pix_ready) got_q.push_back({10'd0, pix_x, pix_y});
        if (!rst && pix_valid && !pix_ready) stall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One triangle end to end. stall_n holds pix_ready low for the first stall_n SCAN
    // cycles; rand_bp randomizes pix_ready and scrambles the vertex inputs while busy;
    // rst_k > 0 asserts reset during cycle rst_k after accept (cycle 1 is BBOX).
    task automatic run_tri(input string tag, input int x1, input int y1, input int x2,
                           input int y2, input int x3, input int y3, input bit use_edge,
                           input int stall_n, input bit rand_bp, input int rst_k);
        int xmn, xmx, ymn, ymx, n_bbox, k, done_k, budget;
        logic [31:0] exp_q[$];
        logic [W-1:0] px_prev, py_prev;
        bit prev_stall;

        ax = x1; ay = y1; bx = x2; by = y2; qx = x3; qy = y3;
        edge_mode = use_edge;
        xmn = x1; xmx = x1; ymn = y1; ymx = y1;
        if (x2 < xmn) xmn = x2;
        if (x3 < xmn) xmn = x3;
        if (x2 > xmx) xmx = x2;
        if (x3 > xmx) xmx = x3;
        if (y2 < ymn) ymn = y2;
        if (y3 < ymn) ymn = y3;
        if (y2 > ymx) ymx = y2;
        if (y3 > ymx) ymx = y3;

        exp_q.delete();
        for (int y = ymn; y <= ymx; y++)
            for (int x = xmn; x <= xmx; x++)
                if (!use_edge || tri_inside(x, y, x1, y1, x2, y2, x3, y3))
                    exp_q.push_back({10'd0, W'(x), W'(y)});
        n_bbox = (xmx - xmn + 1) * (ymx - ymn + 1);
        budget = 4 * n_bbox + 40;

        got_q.delete();
        stall_cnt = 0;
        p1x = W'(x1); p1y = W'(y1); p2x = W'(x2); p2y = W'(y2); p3x = W'(x3); p3y = W'(y3);
        in_valid  = 1'b1;
        pix_ready = 1'b1;
        step();
        in_valid = 1'b0;
        k = 1;
        check({tag, ".bbox_flags"}, {busy, in_ready, pix_valid, done}, 4'b1000);
        check({tag, ".count_clr"}, count, 0);

        done_k     = -1;
        prev_stall = 1'b0;
        px_prev    = '0;
        py_prev    = '0;
        while (done_k < 0 && k < budget) begin
            step();
            k++;
            if (k == 2) check({tag, ".pt_start"}, {pt_x, pt_y}, {W'(xmn), W'(ymn)});
            if (prev_stall) check({tag, ".pt_hold"}, {pt_x, pt_y}, {px_prev, py_prev});
            if (done) begin
                in_valid = 1'b0;
                done_k   = k;
                break;
            end
            if (k == rst_k) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check({tag, ".rst_flags"}, {busy, in_ready, pix_valid, done}, 4'b0100);
                check({tag, ".rst_count"}, count, 0);
                check({tag, ".rst_npix"}, got_q.size(), rst_k - 2);
                for (int i = 0; i < 3; i++) begin
                    step();
                    check({tag, ".rst_quiet"}, {busy, pix_valid, done}, 3'b000);
                end
                return;
            end
            if (rand_bp) begin
                pix_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                p1x = W'($urandom); p1y = W'($urandom); p2x = W'($urandom);
                p2y = W'($urandom); p3x = W'($urandom); p3y = W'($urandom);
            end else begin
                pix_ready = ((k - 1) > stall_n);
            end
            prev_stall = pix_valid && !pix_ready;
            px_prev    = pt_x;
            py_prev    = pt_y;
        end

        in_valid  = 1'b0;
        pix_ready = 1'b1;
        check({tag, ".done_cycle"}, done_k, 2 + n_bbox + stall_cnt);
        check({tag, ".count"}, count, exp_q.size());
        check({tag, ".npix"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, ".pix"}, got_q[i], exp_q[i]);
        step();
        check({tag, ".idle_flags"}, {busy, in_ready, pix_valid, done}, 4'b0100);
        check({tag, ".count_hold"}, count, exp_q.size());
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        stall_cnt = 0;
        edge_mode = 1'b0;
        ax = 0; ay = 0; bx = 0; by = 0; qx = 0; qy = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        pix_ready = 1'b1;
        p1x = 11'd5; p1y = 11'd5; p2x = 11'd6; p2y = 11'd6; p3x = 11'd7; p3y = 11'd5;

        // Reset held two cycles with in_valid high: reset must win.
        step();
        step();
        check("reset.flags", {busy, in_ready, pix_valid, done}, 4'b0100);
        check("reset.count", count, 0);
        check("reset.pt", {pt_x, pt_y}, 22'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        check("reset.idle", {busy, in_ready, done}, 3'b010);

        run_tri("single",   3, 4,   3, 4,   3, 4,  1'b0, 0, 1'b0, 0);
        run_tri("rect",    10, 22, 10, 25, 13, 22, 1'b0, 0, 1'b0, 0);
        run_tri("stall",   10, 22, 10, 25, 13, 22, 1'b0, 3, 1'b0, 0);
        run_tri("midrst",  10, 22, 10, 25, 13, 22, 1'b0, 0, 1'b0, 6);
        run_tri("after",   10, 22, 10, 25, 13, 22, 1'b0, 0, 1'b0, 0);
        run_tri("edge_x",  2045, 0, 2047, 0, 2047, 1, 1'b0, 0, 1'b0, 0);
        run_tri("edge_xm", 2045, 0, 2047, 0, 2047, 1, 1'b1, 0, 1'b0, 0);
        run_tri("colin",    5, 5,   9, 9,   7, 7,  1'b1, 0, 1'b0, 0);
        run_tri("corner", 2047, 2047, 2040, 2047, 2047, 2041, 1'b1, 0, 1'b1, 0);

        for (int t = 0; t < 8; t++) begin
            int bxr, byr;
            bxr = $urandom_range(0, 2037);
            byr = $urandom_range(0, 2037);
            run_tri("rnd",
                    bxr + $urandom_range(0, 10), byr + $urandom_range(0, 10),
                    bxr + $urandom_range(0, 10), byr + $urandom_range(0, 10),
                    bxr + $urandom_range(0, 10), byr + $urandom_range(0, 10),
                    1'b1, 0, 1'b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/triangle_raster.md
TRIANGLE_RASTER -- requirements
Module: triangle_raster

Interface
REQ-001 Parameter W, default 11, coordinate width (unsigned) of every vertex and pixel coordinate.
REQ-002 Parameter CW, default 22, width of pixel counter (2*W).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  vertex set p1..p3 valid.
REQ-006 in_ready  output  1  block idle, vertex set acceptable.
REQ-007 p1x, p1y, p2x, p2y, p3x, p3y  input  W each  triangle vertices.
REQ-008 pt_x, pt_y  output  W each  registered candidate point, wired to the point-in-triangle tester.
REQ-009 inside_in  input  1  combinational tester result for current pt_x/pt_y.
REQ-010 pix_valid  output  1  covered pixel available.
REQ-011 pix_ready  input  1  downstream accepts pixel.
REQ-012 pix_x, pix_y  output  W each  covered pixel coordinates.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at end of triangle.
REQ-015 count  output  CW  number of pixels accepted downstream for current/last triangle.

Function
REQ-016 FSM states IDLE, BBOX, SCAN, DONE; IDLE -> BBOX on in_valid && in_ready; BBOX -> SCAN unconditionally; SCAN -> DONE on final advance; DONE -> IDLE unconditionally.
REQ-017 in_ready shall equal (state == IDLE); in_valid outside IDLE ignored, no effect.
REQ-018 On accept: latch all six vertices, clear count to 0.
REQ-019 BBOX: register xmin/xmax/ymin/ymax as unsigned min/max of latched vertices; load cursor (cx, cy) = (xmin, ymin).
REQ-020 pt_x/pt_y shall equal registered cursor (cx, cy) during SCAN; hold last value otherwise.
REQ-021 pix_valid = (state == SCAN) && inside_in; pix_x/pix_y = pt_x/pt_y.
REQ-022 Advance condition: state == SCAN && (!pix_valid || pix_ready); no advance -> cursor holds, pix_valid/pix_x/pix_y stable.
REQ-023 Scan order row-major: on advance, if cx < xmax then cx+1; else cx = xmin and, if cy < ymax, cy+1.
REQ-024 Final advance at (cx, cy) == (xmax, ymax) -> DONE; comparisons before increment, no wrap at 2^W-1.
REQ-025 Throughput: one point tested per cycle without backpressure; total cycles accept -> done = 2 + (xmax-xmin+1)*(ymax-ymin+1).
REQ-026 count increments by 1 on each pix_valid && pix_ready; saturates at 2^CW-1; holds after DONE until next accept.
REQ-027 done high exactly during DONE state cycle.
REQ-028 Degenerate triangle (coincident or collinear vertices) processed normally; single-point bbox = exactly one test cycle.

Reset
REQ-029 rst high at a clock edge: state = IDLE, pt_x = pt_y = 0, count = 0, cursor and bbox registers = 0; thus in_ready = 1, busy = 0, pix_valid = 0, done = 0.
REQ-030 rst takes priority over all events including in_valid and pix_ready in the same cycle.
REQ-031 Reset mid-scan abandons triangle: no done pulse, no further pixels.

Verification
REQ-032 rst high 2 cycles -> in_ready=1, busy=0, pix_valid=0, done=0, count=0, pt=(0,0).
REQ-033 Accept at T, all vertices (3,4), inside_in=1, pix_ready=1 -> BBOX T+1, pixel (3,4) at T+2, done at T+3, count=1, in_ready=1 at T+4.
REQ-034 Vertices (10,22),(10,25),(13,22), inside_in=1, pix_ready=1 -> 16 pixels row-major (10,22),(11,22)..(13,25), done at T+18, count=16.
REQ-035 Same as REQ-034 with pix_ready=0 for first 3 SCAN cycles -> pt held at (10,22), no duplicate or lost pixel, count=16, done at T+21.
REQ-036 Same as REQ-034, rst asserted during 5th SCAN cycle -> next cycle IDLE, count=0, no done; new vertex set then accepted normally.
REQ-037 Vertices (2045,0),(2047,0),(2047,1), inside_in=1 -> 6 pixels, x never wraps to 0, done after (2047,1), count=6; bench compares inside_in-gated output against behavioural edge-function model.
